// File: rtl/config_loader.sv
// Byte-serial configuration frame loader: SYNC, NB payload bytes, XOR checksum, atomic commit.
// Optional idle timeout in LOAD/CHECK is enabled by defining CFG_TIMEOUT_EN.
module config_loader #(
  parameter int         PROG_W = 116,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  input  logic              err_clr,
  output logic [PROG_W-1:0] prog_out,
  output logic              cfg_done,
  output logic              configured,
  output logic              err,
  output logic              busy
);

  localparam int NB = (PROG_W + 7) / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int IW = CW + 3;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t            state_r;
  logic [PROG_W-1:0] shadow_r;
  logic [PROG_W-1:0] prog_r;
  logic [CW-1:0]     cnt_r;
  logic [7:0]        xor_r;
  logic              cfg_done_r;
  logic              configured_r;
  logic              err_r;
  logic              busy_r;
  logic              in_ready_r;
  logic              accept_s;
  logic              timeout_s;

  assign accept_s = in_valid & in_ready_r;

`ifdef CFG_TIMEOUT_EN
  logic [7:0] idle_r;

  // Counts edges without an accepted byte while a frame is open; expiry fires on the edge it would reach 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_r <= 8'd0;
    end else if (((state_r == LOAD) || (state_r == CHECK)) && !accept_s) begin
      idle_r <= idle_r + 8'd1;
    end else begin
      idle_r <= 8'd0;
    end
  end

  assign timeout_s = (idle_r == 8'd254) & ~accept_s;
`else
  assign timeout_s = 1'b0;
`endif

  // Frame FSM with registered status outputs; abort outranks a byte accepted on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      shadow_r     <= '0;
      prog_r       <= '0;
      cnt_r        <= '0;
      xor_r        <= 8'h00;
      cfg_done_r   <= 1'b0;
      configured_r <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      cfg_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && (in_data == SYNC)) begin
            cnt_r   <= '0;
            xor_r   <= 8'h00;
            busy_r  <= 1'b1;
            state_r <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (accept_s) begin
            // Bytes straddling the top of the word keep only the bits that exist.
            for (int b = 0; b < 8; b++) begin
              if (({cnt_r, 3'b000} + IW'(b)) < IW'(PROG_W)) begin
                shadow_r[{cnt_r, 3'b000} + IW'(b)] <= in_data[b];
              end
            end
            xor_r <= xor_r ^ in_data;
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == LAST) begin
              state_r <= CHECK;
            end
          end else if (timeout_s) begin
            err_r      <= 1'b1;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= ERR;
          end
        end
        CHECK: begin
          if (abort) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (accept_s) begin
            busy_r <= 1'b0;
            if (in_data == xor_r) begin
              prog_r       <= shadow_r;
              configured_r <= 1'b1;
              cfg_done_r   <= 1'b1;
              state_r      <= IDLE;
            end else begin
              err_r      <= 1'b1;
              in_ready_r <= 1'b0;
              state_r    <= ERR;
            end
          end else if (timeout_s) begin
            err_r      <= 1'b1;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= ERR;
          end
        end
        ERR: begin
          if (err_clr) begin
            err_r      <= 1'b0;
            in_ready_r <= 1'b1;
            state_r    <= IDLE;
          end
        end
        default: begin
          err_r      <= 1'b0;
          busy_r     <= 1'b0;
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign prog_out   = prog_r;
  assign cfg_done   = cfg_done_r;
  assign configured = configured_r;
  assign err        = err_r;
  assign busy       = busy_r;
  assign in_ready   = in_ready_r;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: table of whole frames plus hand sequences for
// prefix bytes, abort, asynchronous reset and the idle timeout (CFG_TIMEOUT_EN).
module tb_config_loader;

  localparam int PW = 116;
  localparam int NB = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          abort;
  logic          err_clr;
  logic [PW-1:0] prog_out;
  logic          cfg_done;
  logic          configured;
  logic          err;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] last_prog;

  typedef struct {
    string      name;
    logic [7:0] b0;
    logic [7:0] inc;
    logic [7:0] csum;
    logic       ok;
    logic [PW-1:0] prog;
  } vec_t;

  vec_t vecs[6];

  config_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .abort     (abort),
    .err_clr   (err_clr),
    .prog_out  (prog_out),
    .cfg_done  (cfg_done),
    .configured(configured),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"ones",    8'hFF, 8'h00, 8'hFF, 1'b1, {PW{1'b1}}};
    vecs[1] = '{"badsum",  8'h00, 8'h00, 8'h01, 1'b0, '0};
    vecs[2] = '{"ramp",    8'h01, 8'h01, 8'h00, 1'b1, 116'hF0E0D0C0B0A090807060504030201};
    vecs[3] = '{"syncdat", 8'hA5, 8'h00, 8'hA5, 1'b1, {4'h5, {14{8'hA5}}}};
    vecs[4] = '{"ramp10",  8'h10, 8'h10, 8'h00, 1'b1, 116'h0E0D0C0B0A0908070605040302010};
    vecs[5] = '{"rampbad", 8'h01, 8'h01, 8'hFF, 1'b0, '0};

    reset     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    abort     = 1'b0;
    err_clr   = 1'b0;
    last_prog = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_prog", prog_out, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_cfgd", configured, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    #4;
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      send(8'hA5);
      chk({vecs[i].name, "_busy_load"}, busy, 1);
      for (int k = 0; k < NB; k++) begin
        send(vecs[i].b0 + vecs[i].inc * 8'(k));
      end
      chk({vecs[i].name, "_busy_check"}, busy, 1);
      send(vecs[i].csum);
      if (vecs[i].ok) last_prog = vecs[i].prog;
      chk({vecs[i].name, "_done"}, cfg_done, vecs[i].ok);
      chk({vecs[i].name, "_err"}, err, !vecs[i].ok);
      chk({vecs[i].name, "_cfgd"}, configured, 1);
      chk({vecs[i].name, "_prog"}, prog_out, last_prog);
      chk({vecs[i].name, "_ready"}, in_ready, vecs[i].ok);
      chk({vecs[i].name, "_busy_end"}, busy, 0);
      tick();
      chk({vecs[i].name, "_pulse"}, cfg_done, 0);
      if (!vecs[i].ok) begin
        send(8'hA5);
        repeat (2) tick();
        chk({vecs[i].name, "_err_hold"}, err, 1);
        chk({vecs[i].name, "_ready_hold"}, in_ready, 0);
        chk({vecs[i].name, "_busy_hold"}, busy, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk({vecs[i].name, "_err_clr"}, err, 0);
        chk({vecs[i].name, "_ready_clr"}, in_ready, 1);
        chk({vecs[i].name, "_prog_kept"}, prog_out, last_prog);
      end
    end

    // Leading junk ignored, then a full frame of 0x11 bytes (XOR of fifteen 0x11 is 0x11).
    send(8'h3C);
    chk("junk1_busy", busy, 0);
    send(8'h00);
    chk("junk2_busy", busy, 0);
    send(8'hA5);
    for (int k = 0; k < NB; k++) send(8'h11);
    send(8'h11);
    last_prog = {(PW/4){4'h1}};
    chk("junk_frame_done", cfg_done, 1);
    chk("junk_frame_prog", prog_out, last_prog);

    // Abort after byte 7 with a byte presented on the same edge; the rest must not complete a frame.
    send(8'hA5);
    for (int k = 0; k < 7; k++) send(8'h22);
    in_data  = 8'h22;
    in_valid = 1'b1;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_load_busy", busy, 0);
    chk("abort_load_done", cfg_done, 0);
    for (int k = 0; k < 7; k++) send(8'h22);
    send(8'h22);
    chk("abort_load_nodone", cfg_done, 0);
    chk("abort_load_busy2", busy, 0);
    chk("abort_load_prog", prog_out, last_prog);
    chk("abort_load_cfgd", configured, 1);

    // Abort in CHECK beats a correct checksum; next frame must start from byte 0.
    send(8'hA5);
    for (int k = 0; k < NB; k++) send(8'(k + 1));
    in_data  = 8'h00;
    in_valid = 1'b1;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_chk_done", cfg_done, 0);
    chk("abort_chk_busy", busy, 0);
    chk("abort_chk_prog", prog_out, last_prog);
    send(8'hA5);
    for (int k = 0; k < NB; k++) send(8'(k + 1));
    send(8'h00);
    last_prog = vecs[2].prog;
    chk("after_abort_done", cfg_done, 1);
    chk("after_abort_prog", prog_out, last_prog);

    // Asynchronous reset in the middle of a frame.
    send(8'hA5);
    for (int k = 0; k < 5; k++) send(8'h77);
    #2;
    reset = 1'b0;
    #1;
    chk("async_prog", prog_out, 0);
    chk("async_cfgd", configured, 0);
    chk("async_done", cfg_done, 0);
    chk("async_err", err, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", in_ready, 1);
    #1;
    reset = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    // Idle stall after three payload bytes.
    send(8'hA5);
    for (int k = 0; k < 3; k++) send(8'h5A);
`ifdef CFG_TIMEOUT_EN
    repeat (254) tick();
    chk("to_err_early", err, 0);
    chk("to_busy_early", busy, 1);
    tick();
    chk("to_err", err, 1);
    chk("to_ready", in_ready, 0);
    chk("to_busy", busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clr", err, 0);
`else
    repeat (300) tick();
    chk("stall_err", err, 0);
    chk("stall_busy", busy, 1);
    chk("stall_ready", in_ready, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("stall_abort_busy", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
